// File: rtl/morse_pkg.sv
// morse_pkg: shared state type, pattern width, gap length and letter LUT for the Morse transmitter
package morse_pkg;
  localparam int MORSE_PAT_W = 12;
  localparam int MORSE_GAP_UNITS = 3;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} morse_state_t;
  function automatic logic [MORSE_PAT_W-1:0] morse_pattern(input logic [2:0] sel);
    case (sel)
      3'd0: morse_pattern = 12'b000000011101;
      3'd1: morse_pattern = 12'b000101010111;
      3'd2: morse_pattern = 12'b010111010111;
      3'd3: morse_pattern = 12'b000001010111;
      3'd4: morse_pattern = 12'b000000000001;
      3'd5: morse_pattern = 12'b000101110101;
      3'd6: morse_pattern = 12'b000101110111;
      default: morse_pattern = 12'b000001010101;
    endcase
  endfunction
endpackage

// File: rtl/morse_tx_controller_if.sv
// morse_tx_controller_if: request/status bundle between the board top and the Morse sequencer
interface morse_tx_controller_if;
  logic start;
  logic [2:0] letter_sel;
  logic abort;
  logic ready;
  logic busy;
  logic led;
  logic done;
  modport master (output start, letter_sel, abort, input ready, busy, led, done);
  modport slave (input start, letter_sel, abort, output ready, busy, led, done);
endinterface

// File: rtl/morse_tick_gen.sv
// morse_tick_gen: one-cycle tick every TICK_DIV clocks; clear restarts the unit from zero
module morse_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/morse_tx_controller.sv
// morse_tx_controller: sends one LUT letter LSB-first on led, one symbol per unit tick
// Define MORSE_LETTER_GAP_EN to append a hardware 3-unit inter-letter gap before done.
module morse_tx_controller
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int PAT_W = MORSE_PAT_W
) (
  input logic clk,
  input logic reset,
  morse_tx_controller_if.slave bus
);
  morse_state_t state;
  logic [PAT_W-1:0] shreg;
  logic tick, accept, cancel;
  assign accept = state == IDLE && bus.start && !bus.abort;
  assign cancel = bus.abort && (state == SEND || state == GAP);
  assign bus.ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.led = state == SEND && shreg[0];
  morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(accept || cancel),
    .tick(tick)
  );
`ifdef MORSE_LETTER_GAP_EN
  logic [1:0] gap_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) gap_cnt <= '0;
    else if (state != GAP || cancel) gap_cnt <= '0;
    else if (tick) gap_cnt <= gap_cnt + 2'd1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
    end else if (cancel) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          shreg <= PAT_W'(morse_pattern(bus.letter_sel));
          state <= SEND;
        end
        SEND: if (tick) begin
          shreg <= shreg >> 1;
`ifdef MORSE_LETTER_GAP_EN
          if ((shreg >> 1) == '0) state <= GAP;
`else
          if ((shreg >> 1) == '0) state <= DONE;
`endif
        end
`ifdef MORSE_LETTER_GAP_EN
        GAP: if (tick && gap_cnt == 2'(MORSE_GAP_UNITS - 1)) state <= DONE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_tx_controller.sv
// tb_morse_tx_controller: table-driven letter checks plus abort, reset and busy-start corner cases
module tb_morse_tx_controller;
  localparam int TD = 4;
  typedef struct {
    logic [2:0] sel;
    logic [11:0] pat;
    int units;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t tbl[8];
  morse_tx_controller_if bus ();
  morse_tx_controller #(.TICK_DIV(TD)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_letter(input vec_t v, input bit mid_start);
    int dones = 0;
    bus.start = 1'b1;
    bus.letter_sel = v.sel;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= v.units * TD; c++) begin
      if (mid_start) bus.start = (c == 10);
      if (mid_start && c == 10) bus.letter_sel = 3'd4;
      chk($sformatf("led sel%0d c%0d", v.sel, c), bus.led, v.pat[(c - 1) / TD]);
      chk($sformatf("busy sel%0d c%0d", v.sel, c), bus.busy, 1'b1);
      dones += int'(bus.done);
      step();
    end
    bus.start = 1'b0;
`ifdef MORSE_LETTER_GAP_EN
    for (int c = 0; c < 3 * TD; c++) begin
      chk($sformatf("gap led sel%0d c%0d", v.sel, c), bus.led, 1'b0);
      chk($sformatf("gap busy sel%0d c%0d", v.sel, c), bus.busy, 1'b1);
      dones += int'(bus.done);
      step();
    end
`endif
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL early done sel%0d: got %0d pulses want 0", v.sel, dones);
    end
    chk($sformatf("done sel%0d", v.sel), bus.done, 1'b1);
    chk($sformatf("done ready sel%0d", v.sel), bus.ready, 1'b0);
    chk($sformatf("done led sel%0d", v.sel), bus.led, 1'b0);
    step();
    chk($sformatf("after done sel%0d", v.sel), bus.done, 1'b0);
    chk($sformatf("ready sel%0d", v.sel), bus.ready, 1'b1);
    chk($sformatf("idle busy sel%0d", v.sel), bus.busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{3'd0, 12'b000000011101, 5};
    tbl[1] = '{3'd1, 12'b000101010111, 9};
    tbl[2] = '{3'd2, 12'b010111010111, 11};
    tbl[3] = '{3'd3, 12'b000001010111, 7};
    tbl[4] = '{3'd4, 12'b000000000001, 1};
    tbl[5] = '{3'd5, 12'b000101110101, 9};
    tbl[6] = '{3'd6, 12'b000101110111, 9};
    tbl[7] = '{3'd7, 12'b000001010101, 7};
    bus.start = 1'b0;
    bus.letter_sel = 3'd0;
    bus.abort = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst ready", bus.ready, 1'b1);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst led", bus.led, 1'b0);
    chk("rst done", bus.done, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 8; i++) run_letter(tbl[i], 1'b0);
    run_letter(tbl[2], 1'b1);
    // start together with abort in IDLE must not launch a letter
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start+abort ready", bus.ready, 1'b1);
    chk("start+abort led", bus.led, 1'b0);
    bus.start = 1'b1;
    bus.letter_sel = 3'd7;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      chk($sformatf("H led c%0d", c), bus.led, tbl[7].pat[(c - 1) / TD]);
      step();
    end
    bus.abort = 1'b1;
    chk("H busy c6", bus.busy, 1'b1);
    step();
    bus.abort = 1'b0;
    chk("abort ready", bus.ready, 1'b1);
    chk("abort led", bus.led, 1'b0);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    step();
    chk("abort no done", bus.done, 1'b0);
    run_letter(tbl[4], 1'b0);
    bus.start = 1'b1;
    bus.letter_sel = 3'd1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("B led pre-reset", bus.led, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid rst led", bus.led, 1'b0);
    chk("mid rst busy", bus.busy, 1'b0);
    chk("mid rst done", bus.done, 1'b0);
    chk("mid rst ready", bus.ready, 1'b1);
    step();
    reset = 1'b0;
    step();
    chk("post rst done", bus.done, 1'b0);
    chk("post rst ready", bus.ready, 1'b1);
    run_letter(tbl[0], 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
